instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Producer end of the decoder's instruction interface: fetches 32-bit RV32I instruction words from instruction memory and presents them to the decoder.
- Each word is presented with its PC on `instr` / `pc`, qualified by `req`.
- Owns the fetch PC and the sequential +4 increment.
- Accepts branch/jump redirects from the execute stage and discards stale memory responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.

Ports:
- clk  input  1  system clock; all logic on the rising edge
- reset  input  1  synchronous, active-high reset
- mem_req  output  1  memory read request; held high until mem_ack
- mem_addr  output  32  word-aligned read address; stable while mem_req=1
- mem_ack  input  1  one-cycle pulse; mem_rdata valid in the same cycle
- mem_rdata  input  32  instruction word
- req  output  1  instr/pc valid toward decoder
- instr  output  32  instruction word toward decoder
- pc  output  32  address of instr
- dec_ready  input  1  decoder consumes instr this cycle when req=1
- redirect  input  1  one-cycle pulse: restart fetch at redirect_pc
- redirect_pc  input  32  new fetch address; bits [1:0] forced to 0 internally

Behaviour:
- Reset values:
  - state = FETCH, fetch_pc = RESET_PC.
  - mem_req = 0, mem_addr = RESET_PC.
  - req = 0, instr = 32'h0000_0013 (NOP), pc = RESET_PC.
- During reset, all inputs are ignored and mem_req is 0.
- FETCH state:
  - mem_req = 1, mem_addr = fetch_pc. Registered: high from the first cycle after reset deasserts.
  - On mem_ack with no redirect: instr <= mem_rdata, pc <= fetch_pc, req <= 1, fetch_pc <= fetch_pc + 4 (mod 2^32, wraps FFFF_FFFC -> 0), go to HOLD.
- HOLD state:
  - mem_req = 0, req = 1, instr/pc stable.
  - On dec_ready: req <= 0, go to FETCH.
- FLUSH state:
  - mem_req stays 1 with the old mem_addr, because an issued request cannot be withdrawn.
  - On mem_ack: mem_rdata is discarded, go to FETCH at the stored target.
- At most one request is outstanding.
- Latency: fetch_pc to req = 1 cycle + memory latency. Peak throughput is one instruction per 2 cycles with zero-wait memory.
- Redirect handling (redirect has priority over every other event):
  - FETCH, no ack same cycle: fetch_pc <= redirect_pc & ~3, go to FLUSH.
  - FETCH, ack same cycle: response discarded (req stays 0), fetch_pc <= target, stay in FETCH. mem_addr updates the next cycle.
  - HOLD: req <= 0 next cycle. If dec_ready is also high, the word counts as consumed. fetch_pc <= target, go to FETCH.
  - FLUSH: target overwritten by the newest redirect_pc, stay in FLUSH (or go to FETCH if ack in the same cycle).
- dec_ready is ignored when req = 0.
- mem_ack is ignored when mem_req = 0; the bench flags it as a protocol error.
- Reset mid-request: the state machine returns to reset values. A memory ack arriving later is ignored because mem_req = 0.

Decomposition:
- Shared package:
  - State encoding FETCH/HOLD/FLUSH (2 bits).
  - NOP_INSTR = 32'h0000_0013.
  - Default RESET_PC.
  - PC_STEP = 4.
- Single flat module; no sub-module is warranted. The PC incrementer stays inline.

Test Plan:
1. Reset, RESET_PC=0, zero-wait memory returning addr^32'hA5A5_0000, dec_ready=1 -> mem_addr sequence 0,4,8,...; req pulses every 2nd cycle with pc=0,4,8 and matching instr.
2. dec_ready=0 for 5 cycles after first word -> req, instr, pc stable for 5 cycles; mem_req=0 throughout; fetch of 4 starts the cycle after dec_ready=1.
3. Memory latency 3, redirect to 32'h100 one cycle after mem_req rises -> mem_addr stays at the old value until ack; that ack's data is never presented; next mem_addr=0x100; req then shows pc=0x100.
4. Redirect to 32'h203 coinciding with mem_ack -> no req for that word; next mem_addr=0x200.
5. Redirect to 0x40 then 0x80 in consecutive cycles during FLUSH -> fetch resumes at 0x80 only.
6. fetch_pc=32'hFFFF_FFFC, ack -> pc=FFFF_FFFC presented; next mem_addr=0. Reset asserted during outstanding request -> mem_req=0, req=0, pc=RESET_PC next cycle.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_pkg;

   // Fetch controller states
   typedef enum logic [1:0] {
      StFetch = 2'd0,
      StHold  = 2'd1,
      StFlush = 2'd2
   } state_e;

   localparam logic [31:0] NopInstr       = 32'h0000_0013;  // addi x0, x0, 0
   localparam logic [31:0] DefaultResetPc = 32'h0000_0000;
   localparam logic [31:0] PcStep         = 32'd4;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: issues one memory read at a time, presents each word with
// its PC to the decoder, and restarts at a new address on redirect. Responses to
// requests that were already issued when a redirect arrived are discarded.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DefaultResetPc
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        req,
   output logic [31:0] instr,
   output logic [31:0] pc,
   input  logic        dec_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);

   state_e      state_q, state_d;
   logic        mem_req_q, mem_req_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic        req_q, req_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q, pc_d;

   logic [31:0] target;
   logic [31:0] pc_inc;
   logic        ack_valid;

   assign target    = redirect_pc & ~32'h0000_0003;
   assign pc_inc    = fetch_pc_q + PcStep;
   // An ack only means something while our request is on the bus
   assign ack_valid = mem_req_q & mem_ack;

   // Next-state logic; redirect takes priority over every other event
   always_comb begin
      state_d    = state_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      fetch_pc_d = fetch_pc_q;
      req_d      = req_q;
      instr_d    = instr_q;
      pc_d       = pc_q;

      case (state_q)
         StFetch: begin
            mem_req_d = 1'b1;
            if (redirect) begin
               fetch_pc_d = target;
               if (mem_req_q && !ack_valid) begin
                  // Request already issued: let it complete at the old address
                  state_d = StFlush;
               end else begin
                  // Nothing pending (or response dropped this cycle): restart now
                  mem_addr_d = target;
               end
            end else if (ack_valid) begin
               instr_d    = mem_rdata;
               pc_d       = fetch_pc_q;
               req_d      = 1'b1;
               fetch_pc_d = pc_inc;
               mem_addr_d = pc_inc;
               mem_req_d  = 1'b0;
               state_d    = StHold;
            end
         end

         StHold: begin
            if (redirect) begin
               req_d      = 1'b0;
               fetch_pc_d = target;
               mem_addr_d = target;
               mem_req_d  = 1'b1;
               state_d    = StFetch;
            end else if (dec_ready) begin
               req_d     = 1'b0;
               mem_req_d = 1'b1;
               state_d   = StFetch;
            end
         end

         StFlush: begin
            mem_req_d = 1'b1;
            if (redirect) begin
               fetch_pc_d = target;
            end
            if (ack_valid) begin
               // Stale response dropped; start the real fetch
               mem_addr_d = redirect ? target : fetch_pc_q;
               state_d    = StFetch;
            end
         end

         default: begin
            state_d = StFetch;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StFetch;
         mem_req_q  <= 1'b0;
         mem_addr_q <= RESET_PC;
         fetch_pc_q <= RESET_PC;
         req_q      <= 1'b0;
         instr_q    <= NopInstr;
         pc_q       <= RESET_PC;
      end else begin
         state_q    <= state_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         fetch_pc_q <= fetch_pc_d;
         req_q      <= req_d;
         instr_q    <= instr_d;
         pc_q       <= pc_d;
      end
   end

   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;
   assign req      = req_q;
   assign instr    = instr_q;
   assign pc       = pc_q;

endmodule
